shift_right_unit: RTL and testbench
===================================

Name: shift_right_unit

Overview:
- Iterative multi-cycle right shifter for the EX stage. Executes SRL/SRA and the variable forms SRLV/SRAV.
- Shifts at most STEP bit positions per clock, replacing a full 32-bit barrel shifter.
- Uses a start/busy/done handshake; hazard logic stalls the pipeline while busy=1.

Parameters:
- STEP, 4: maximum bit positions shifted per cycle; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  operation request; sampled only in IDLE or DONE.
- flush  input  1  synchronous abort from pipeline flush.
- x  input  32  operand, sampled when start is accepted.
- shamt  input  5  shift amount 0..31, sampled when start is accepted.
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); sampled when start is accepted.
- y  output  32  result register.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse; y is valid in that cycle.

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, y=0, busy=0, done=0, internal regs=0. rst overrides all other inputs, including mid-operation.
- States:
  - IDLE: start=1 latches x into the work register, shamt into rem, and arith and x[31] into the fill bit. Next state is DONE if shamt==0, else SHIFT. start=0 stays in IDLE.
  - SHIFT: each cycle, k = min(STEP, rem). Work register shifts right by k, filling vacated MSBs with the fill bit (arith=1) or 0 (arith=0); rem -= k. When rem reaches 0, y <= shifted value and next state is DONE. start is ignored in SHIFT.
  - DONE: done=1 for exactly this cycle. start=1 accepts new operands exactly as in IDLE (back-to-back issue). Otherwise next state is IDLE.
- Latency: done is high in cycle ceil(shamt/STEP)+1 after the start cycle. For shamt==0, done is high in the next cycle with y=x.
- busy = (state==SHIFT). The shamt==0 path never raises busy.
- y holds its value from DONE until the next completion; it does not change during SHIFT.
- flush=1: next state is IDLE, busy=0, done=0 next cycle, y unchanged, in-flight result discarded.
- Priority: rst > flush > start. flush together with start in IDLE leaves the unit idle.
- Fill bit is latched x[31] at start, not the live work-register MSB (identical for SRA, stated for clarity).
- rem is 5 bits. k never exceeds rem, so rem cannot underflow.
- start is ignored in SHIFT; the issuing stage must hold the instruction until done.

Optional Feature:
- Macro SHIFT_LEFT_EN.
- When defined:
  - Adds input dir (1 bit; 1 = left), sampled with start.
  - Left mode shifts the work register left by k per cycle with zero fill; arith is ignored.
  - Supports SLL/SLLV on the same unit with identical latency and handshake.
- When undefined:
  - No dir port; right shifts only.
  - No left-shift logic synthesized.

Test Plan:
- STEP=4, start with x=0x80000000, shamt=31, arith=0 -> busy high for 8 cycles; done in cycle 9 after start; y=0x00000001.
- STEP=4, x=0x80000000, shamt=4, arith=1 -> done in cycle 2; y=0xF8000000. Repeat with arith=0 -> y=0x08000000.
- x=0xDEADBEEF, shamt=0 -> done in cycle 1, y=0xDEADBEEF, busy never asserted.
- STEP=4, x=0x12345678, shamt=8, arith=0; a second start with x=0 one cycle later -> second start ignored; done in cycle 3, y=0x00123456. A start asserted in the DONE cycle with x=0xF0000000, shamt=4, arith=1 -> next done 2 cycles later, y=0xFF000000.
- Mid-operation abort: start shamt=31, assert flush in cycle 3 -> busy=0 next cycle, no done pulse, y retains prior result. Repeat with rst instead of flush -> y=0, all outputs 0.
- SHIFT_LEFT_EN defined: dir=1, x=0x00000001, shamt=2 -> done in cycle 2, y=0x00000004. dir=1, x=0x80000001, shamt=31 -> y=0x80000000.

Source files
------------

// File: rtl/shift_right_unit.sv
// Iterative multi-cycle shifter for the EX stage: at most STEP bit positions per clock.
// Optional macro SHIFT_LEFT_EN adds a dir input (1 = left, zero fill) for SLL/SLLV.
module shift_right_unit #(
    parameter int unsigned STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] x,
    input  logic [4:0]  shamt,
    input  logic        arith,
`ifdef SHIFT_LEFT_EN
    input  logic        dir,
`endif
    output logic [31:0] y,
    output logic        busy,
    output logic        done
);

    localparam int unsigned W   = 32;
    localparam int unsigned SW  = 5;
    localparam logic [SW-1:0] STEP_K = SW'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_work, w_work_nxt;
    logic [SW-1:0] r_rem, w_rem_nxt;
    logic          r_fill, w_fill_nxt;
    logic [W-1:0]  r_y, w_y_nxt;
    logic          r_busy;
    logic          r_done;
    logic [SW-1:0] w_k;
    logic [W-1:0]  w_shift_r;
    logic [W-1:0]  w_shifted;
`ifdef SHIFT_LEFT_EN
    logic          r_left, w_left_nxt;
`endif

    // Step size this cycle never exceeds the remaining count, so rem cannot underflow.
    assign w_k       = (r_rem < STEP_K) ? r_rem : STEP_K;
    assign w_shift_r = (r_work >> w_k) | ({W{r_fill}} & ~({W{1'b1}} >> w_k));
`ifdef SHIFT_LEFT_EN
    assign w_shifted = r_left ? (r_work << w_k) : w_shift_r;
`else
    assign w_shifted = w_shift_r;
`endif

    // Next-state and datapath update; flush outranks any start request.
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_rem_nxt   = r_rem;
        w_fill_nxt  = r_fill;
        w_y_nxt     = r_y;
`ifdef SHIFT_LEFT_EN
        w_left_nxt  = r_left;
`endif
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    w_state_nxt = S_IDLE;
                    if (start) begin
                        w_work_nxt = x;
                        w_rem_nxt  = shamt;
                        w_fill_nxt = arith & x[W-1];
`ifdef SHIFT_LEFT_EN
                        w_left_nxt = dir;
`endif
                        if (shamt == '0) begin
                            w_y_nxt     = x;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    w_work_nxt = w_shifted;
                    w_rem_nxt  = r_rem - w_k;
                    if (r_rem == w_k) begin
                        w_y_nxt     = w_shifted;
                        w_state_nxt = S_DONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_rem   <= '0;
            r_fill  <= 1'b0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SHIFT_LEFT_EN
            r_left  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_rem   <= w_rem_nxt;
            r_fill  <= w_fill_nxt;
            r_y     <= w_y_nxt;
            r_busy  <= (w_state_nxt == S_SHIFT);
            r_done  <= (w_state_nxt == S_DONE);
`ifdef SHIFT_LEFT_EN
            r_left  <= w_left_nxt;
`endif
        end
    end

    assign y    = r_y;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_shift_right_unit.sv
// Directed bench for shift_right_unit: a scoreboard queue holds expected result and done cycle.
module tb_shift_right_unit;

    localparam int unsigned STEP = 4;

    typedef struct {
        logic [31:0] y;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [31:0] x;
    logic [4:0]  shamt;
    logic        arith;
`ifdef SHIFT_LEFT_EN
    logic        dir;
`endif
    logic [31:0] y;
    logic        busy;
    logic        done;

    int unsigned cyc;
    int          checks;
    int          errors;
    exp_t        q[$];

    shift_right_unit #(.STEP(STEP)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .flush (flush),
        .x     (x),
        .shamt (shamt),
        .arith (arith),
`ifdef SHIFT_LEFT_EN
        .dir   (dir),
`endif
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d expected bench to finish", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic int unsigned lat(input logic [4:0] s);
        if (s == 5'd0) return 1;
        return (int'(s) + STEP - 1) / STEP + 1;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every done pulse must match the oldest outstanding expectation in value and timing.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_done cyc=%0d y=%h expected no done", cyc, y);
            end
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                assert (y === e.y) else begin
                    errors++;
                    $error("FAIL result observed=%h expected=%h", y, e.y);
                end
                checks++;
                assert (cyc == e.cyc) else begin
                    errors++;
                    $error("FAIL done_cycle observed=%0d expected=%0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] ix, input logic [4:0] ish, input logic iar,
                         input logic [31:0] ey);
        @(posedge clk); #1;
        start = 1'b1; x = ix; shamt = ish; arith = iar;
`ifdef SHIFT_LEFT_EN
        dir = 1'b0;
`endif
        q.push_back('{y: ey, cyc: cyc + lat(ish)});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

`ifdef SHIFT_LEFT_EN
    task automatic issue_left(input logic [31:0] ix, input logic [4:0] ish, input logic [31:0] ey);
        @(posedge clk); #1;
        start = 1'b1; x = ix; shamt = ish; arith = 1'b1; dir = 1'b1;
        q.push_back('{y: ey, cyc: cyc + lat(ish)});
        @(posedge clk); #1;
        start = 1'b0; dir = 1'b0;
    endtask
`endif

    // Wait for the scoreboard to empty, counting busy cycles along the way.
    task automatic drain(input string tag, output int busy_n);
        int n;
        n = 0;
        busy_n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            n++;
        end
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL %s_timeout pending=%0d expected 0", tag, q.size());
        end
    endtask

    initial begin
        int bn;
        checks = 0;
        errors = 0;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        x = '0; shamt = '0; arith = 1'b0;
`ifdef SHIFT_LEFT_EN
        dir = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("reset_y", y, 32'h0);
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
        drain("srl31", bn);
        checki("srl31_busy_cycles", bn, 8);

        issue(32'h8000_0000, 5'd4, 1'b1, 32'hF800_0000);
        drain("sra4", bn);
        checki("sra4_busy_cycles", bn, 1);

        issue(32'h8000_0000, 5'd4, 1'b0, 32'h0800_0000);
        drain("srl4", bn);

        issue(32'hDEAD_BEEF, 5'd0, 1'b1, 32'hDEAD_BEEF);
        drain("sh0", bn);
        checki("sh0_busy_cycles", bn, 0);

        issue(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
        drain("sra31", bn);
        issue(32'h7FFF_FFFF, 5'd5, 1'b1, 32'h03FF_FFFF);
        drain("sra5_pos", bn);
        issue(32'hC000_0003, 5'd1, 1'b1, 32'hE000_0001);
        drain("sra1", bn);

        // Start during SHIFT is ignored; start in the DONE cycle is accepted back-to-back.
        @(posedge clk); #1;
        start = 1'b1; x = 32'h1234_5678; shamt = 5'd8; arith = 1'b0;
        q.push_back('{y: 32'h0012_3456, cyc: cyc + 3});
        @(posedge clk); #1;
        x = 32'h0; shamt = 5'd8;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; x = 32'hF000_0000; shamt = 5'd4; arith = 1'b1;
        q.push_back('{y: 32'hFF00_0000, cyc: cyc + 2});
        @(posedge clk); #1;
        start = 1'b0;
        drain("b2b", bn);

        // Flush mid-operation: no done, result unchanged.
        issue(32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0);
        void'(q.pop_back());
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check1("flush_busy_before", busy, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check1("flush_busy", busy, 1'b0);
        check1("flush_done", done, 1'b0);
        check32("flush_y", y, 32'hFF00_0000);
        repeat (12) @(negedge clk);
        check32("flush_y_later", y, 32'hFF00_0000);

        // Reset mid-operation clears everything.
        issue(32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0);
        void'(q.pop_back());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check32("rst_y", y, 32'h0);
        repeat (12) @(negedge clk);

        // flush with start in IDLE leaves the unit idle.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; x = 32'hAAAA_AAAA; shamt = 5'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check1("flush_start_done", done, 1'b0);
        check1("flush_start_busy", busy, 1'b0);
        repeat (4) @(negedge clk);
        check32("flush_start_y", y, 32'h0);

`ifdef SHIFT_LEFT_EN
        issue_left(32'h0000_0001, 5'd2, 32'h0000_0004);
        drain("sll2", bn);
        checki("sll2_busy_cycles", bn, 1);
        issue_left(32'h8000_0001, 5'd31, 32'h8000_0000);
        drain("sll31", bn);
        issue(32'h8000_0000, 5'd4, 1'b1, 32'hF800_0000);
        drain("sra_after_left", bn);
`endif

        repeat (3) @(negedge clk);
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_empty pending=%0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
